vproc_cfg_unit: RTL and testbench

- Executes the `UNIT_CFG` pseudo-unit operations, i.e. everything carrying an `op_mode_cfg` decoded by the instruction decoder: `vsetvl*` and the vector CSR accesses.
- Owns the architectural vector state (vtype, vl, vstart, vxrm, vxsat) and broadcasts it to the pipeline.
- Sits beside the dispatcher: it receives committed or speculative config ops and returns the scalar result for rd over a valid/ready result port.

---
 rtl/vproc_cfg_unit_pkg.sv | 89 ++++++++
 rtl/vproc_cfg_unit_if.sv | 33 +++
 rtl/vproc_cfg_vlmax.sv | 47 ++++
 rtl/vproc_cfg_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_vproc_cfg_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vproc_cfg_unit_pkg.sv
// Shared types for the vector configuration unit: decoded config ops, vtype fields,
// FSM states and the vtype CSR packing helper.
package vproc_cfg_unit_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'd0,
    VSEW_16      = 2'd1,
    VSEW_32      = 2'd2,
    VSEW_INVALID = 2'd3
  } cfg_vsew;

  // Fractional codes are chosen so that the right-shift amount is (8 - code).
  typedef enum logic [2:0] {
    LMUL_1       = 3'd0,
    LMUL_2       = 3'd1,
    LMUL_4       = 3'd2,
    LMUL_8       = 3'd3,
    LMUL_INVALID = 3'd4,
    LMUL_F8      = 3'd5,
    LMUL_F4      = 3'd6,
    LMUL_F2      = 3'd7
  } cfg_lmul;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'd0,
    VXRM_RNE = 2'd1,
    VXRM_RDN = 2'd2,
    VXRM_ROD = 2'd3
  } cfg_vxrm;

  typedef enum logic [3:0] {
    CFG_VSETVL       = 4'd0,
    CFG_VTYPE_READ   = 4'd1,
    CFG_VL_READ      = 4'd2,
    CFG_VLENB_READ   = 4'd3,
    CFG_VSTART_WRITE = 4'd4,
    CFG_VSTART_SET   = 4'd5,
    CFG_VSTART_CLEAR = 4'd6,
    CFG_VXSAT_WRITE  = 4'd7,
    CFG_VXSAT_SET    = 4'd8,
    CFG_VXSAT_CLEAR  = 4'd9,
    CFG_VXRM_WRITE   = 4'd10,
    CFG_VXRM_SET     = 4'd11,
    CFG_VXRM_CLEAR   = 4'd12,
    CFG_VCSR_WRITE   = 4'd13,
    CFG_VCSR_SET     = 4'd14,
    CFG_VCSR_CLEAR   = 4'd15
  } cfg_op;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2
  } cfg_csr_kind;

  typedef struct packed {
    cfg_op      op;
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    WAIT_DRAIN  = 2'd2,
    RESULT      = 2'd3
  } cfg_fsm_state;

  localparam int unsigned CFG_VTYPE_VILL_BIT = 31;

  // An illegal vtype reads back as vill alone; all other fields are zero.
  function automatic logic [31:0] cfg_vtype_pack(logic vill, logic [1:0] agnostic,
                                                 cfg_vsew vsew, cfg_lmul lmul);
    logic [31:0] vtype;
    vtype = '0;
    if (vill) begin
      vtype[CFG_VTYPE_VILL_BIT] = 1'b1;
    end else begin
      vtype[7:6] = agnostic;
      vtype[5:3] = {1'b0, vsew};
      vtype[2:0] = lmul;
    end
    return vtype;
  endfunction

endpackage

// File: rtl/vproc_cfg_unit_if.sv
// Op, commit and result handshake bundle between the dispatcher and vproc_cfg_unit.
interface vproc_cfg_unit_if #(
  parameter int unsigned ID_W = 3
);
  import vproc_cfg_unit_pkg::*;

  logic            op_valid_i;
  logic            op_ready_o;
  logic [ID_W-1:0] op_id_i;
  logic            op_spec_i;
  op_mode_cfg      op_mode_i;
  logic [31:0]     op_rs1_i;
  logic            commit_valid_i;
  logic [ID_W-1:0] commit_id_i;
  logic            commit_kill_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [ID_W-1:0] res_id_o;
  logic [31:0]     res_data_o;

  modport slave (
    input  op_valid_i, op_id_i, op_spec_i, op_mode_i, op_rs1_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, res_ready_i,
    output op_ready_o, res_valid_o, res_id_o, res_data_o
  );

  modport master (
    output op_valid_i, op_id_i, op_spec_i, op_mode_i, op_rs1_i,
    output commit_valid_i, commit_id_i, commit_kill_i, res_ready_i,
    input  op_ready_o, res_valid_o, res_id_o, res_data_o
  );

endinterface

// File: rtl/vproc_cfg_vlmax.sv
// Combinational vlmax / vill evaluation for a requested (vsew, lmul) pair.
module vproc_cfg_vlmax
  import vproc_cfg_unit_pkg::*;
#(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned CFG_VL_W = $clog2(VREG_W) + 1
) (
  input  cfg_vsew             vsew_i,
  input  cfg_lmul             lmul_i,
  output logic [CFG_VL_W-1:0] vlmax_o,
  output logic                vill_o
);

  localparam logic [CFG_VL_W-1:0] VLENB = CFG_VL_W'(VREG_W / 8);

  logic [CFG_VL_W-1:0] grp_bytes;
  logic                sew_too_wide;

  always_comb begin
    grp_bytes    = '0;
    sew_too_wide = 1'b0;
    case (lmul_i)
      LMUL_1:  grp_bytes = VLENB;
      LMUL_2:  grp_bytes = VLENB << 1;
      LMUL_4:  grp_bytes = VLENB << 2;
      LMUL_8:  grp_bytes = VLENB << 3;
      // Fractional groups are only legal while SEW <= 32 * LMUL.
      LMUL_F2: begin
        grp_bytes    = VLENB >> 1;
        sew_too_wide = (vsew_i == VSEW_32);
      end
      LMUL_F4: begin
        grp_bytes    = VLENB >> 2;
        sew_too_wide = (vsew_i != VSEW_8);
      end
      LMUL_F8: begin
        grp_bytes    = VLENB >> 3;
        sew_too_wide = 1'b1;
      end
      default: grp_bytes = '0;
    endcase
    vlmax_o = grp_bytes >> vsew_i;
    vill_o  = (vsew_i == VSEW_INVALID) || (lmul_i == LMUL_INVALID) ||
              sew_too_wide || (vlmax_o == '0);
  end

endmodule

// File: rtl/vproc_cfg_unit.sv
// Executes vsetvl* and vector CSR ops and owns vtype/vl/vstart/vxrm/vxsat.
// Define VPROC_CFG_VSTART_EN to implement a writable vstart register.
module vproc_cfg_unit
  import vproc_cfg_unit_pkg::*;
#(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned CFG_VL_W = $clog2(VREG_W) + 1
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  vproc_cfg_unit_if.slave     bus,
  input  logic                pipe_idle_i,
  input  logic                vxsat_set_i,
  output cfg_vsew             vsew_o,
  output cfg_lmul             lmul_o,
  output logic                vill_o,
  output logic [CFG_VL_W-1:0] vl_o,
  output logic                vl_0_o,
  output cfg_vxrm             vxrm_o,
  output logic [CFG_VL_W-1:0] vstart_o
);

`ifdef VPROC_CFG_VSTART_EN
  localparam int unsigned CSR_W = CFG_VL_W;
`else
  localparam int unsigned CSR_W = 3;
`endif

  cfg_fsm_state        state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  op_mode_cfg          mode_q, mode_d;
  logic [31:0]         rs1_q, rs1_d;
  logic [31:0]         res_data_q, res_data_d;
  cfg_vsew             vsew_q, vsew_d;
  cfg_lmul             lmul_q, lmul_d;
  logic [1:0]          agn_q, agn_d;
  logic                vill_q, vill_d;
  logic [CFG_VL_W-1:0] vl_q, vl_d;
  cfg_vxrm             vxrm_q, vxrm_d;
  logic                vxsat_q, vxsat_d;
  logic [CSR_W-1:0]    vstart_val;
`ifdef VPROC_CFG_VSTART_EN
  logic [CFG_VL_W-1:0] vstart_q, vstart_d;
  assign vstart_val = vstart_q;
`else
  assign vstart_val = '0;
`endif

  logic [CFG_VL_W-1:0] vlmax;
  logic                vlmax_vill;
  logic [CFG_VL_W-1:0] vl_new;
  logic                proceed;
  cfg_csr_kind         csr_kind;
  logic [CSR_W-1:0]    csr_old, csr_new, rs1_n;

  vproc_cfg_vlmax #(
    .VREG_W   (VREG_W),
    .CFG_VL_W (CFG_VL_W)
  ) i_vlmax (
    .vsew_i  (mode_q.vsew),
    .lmul_i  (mode_q.lmul),
    .vlmax_o (vlmax),
    .vill_o  (vlmax_vill)
  );

  // Pure reads never touch state the in-flight pipeline depends on.
  assign proceed = pipe_idle_i || (mode_q.op inside {CFG_VTYPE_READ, CFG_VL_READ, CFG_VLENB_READ});
  assign rs1_n   = rs1_q[CSR_W-1:0];

  always_comb begin
    if (mode_q.vlmax) begin
      vl_new = vlmax;
    end else if (mode_q.keep_vl) begin
      vl_new = vl_q;
    end else if (rs1_q < 32'(vlmax)) begin
      vl_new = rs1_q[CFG_VL_W-1:0];
    end else begin
      vl_new = vlmax;
    end
  end

  always_comb begin
    csr_old  = '0;
    csr_kind = CSR_WRITE;
    case (mode_q.op)
      CFG_VSTART_WRITE, CFG_VSTART_SET, CFG_VSTART_CLEAR: csr_old = vstart_val;
      CFG_VXSAT_WRITE, CFG_VXSAT_SET, CFG_VXSAT_CLEAR:    csr_old = CSR_W'(vxsat_q);
      CFG_VXRM_WRITE, CFG_VXRM_SET, CFG_VXRM_CLEAR:       csr_old = CSR_W'(vxrm_q);
      CFG_VCSR_WRITE, CFG_VCSR_SET, CFG_VCSR_CLEAR:       csr_old = CSR_W'({vxrm_q, vxsat_q});
      default: csr_old = '0;
    endcase
    case (mode_q.op)
      CFG_VSTART_SET, CFG_VXSAT_SET, CFG_VXRM_SET, CFG_VCSR_SET:         csr_kind = CSR_SET;
      CFG_VSTART_CLEAR, CFG_VXSAT_CLEAR, CFG_VXRM_CLEAR, CFG_VCSR_CLEAR: csr_kind = CSR_CLEAR;
      default:                                                           csr_kind = CSR_WRITE;
    endcase
    case (csr_kind)
      CSR_SET:   csr_new = csr_old | rs1_n;
      CSR_CLEAR: csr_new = csr_old & ~rs1_n;
      default:   csr_new = rs1_n;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    mode_d     = mode_q;
    rs1_d      = rs1_q;
    res_data_d = res_data_q;
    vsew_d     = vsew_q;
    lmul_d     = lmul_q;
    agn_d      = agn_q;
    vill_d     = vill_q;
    vl_d       = vl_q;
    vxrm_d     = vxrm_q;
    vxsat_d    = vxsat_q;
`ifdef VPROC_CFG_VSTART_EN
    vstart_d   = vstart_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.op_valid_i) begin
          id_d    = bus.op_id_i;
          mode_d  = bus.op_mode_i;
          rs1_d   = bus.op_rs1_i;
          state_d = bus.op_spec_i ? WAIT_COMMIT : WAIT_DRAIN;
        end
      end
      WAIT_COMMIT: begin
        if (bus.commit_valid_i && (bus.commit_id_i == id_q)) begin
          state_d = bus.commit_kill_i ? IDLE : WAIT_DRAIN;
        end
      end
      WAIT_DRAIN: begin
        if (proceed) begin
          state_d    = RESULT;
          res_data_d = '0;
          case (mode_q.op)
            CFG_VSETVL: begin
              if (vlmax_vill) begin
                vill_d = 1'b1;
                vl_d   = '0;
              end else begin
                vill_d     = 1'b0;
                vsew_d     = mode_q.vsew;
                lmul_d     = mode_q.lmul;
                agn_d      = mode_q.agnostic;
                vl_d       = vl_new;
                res_data_d = 32'(vl_new);
`ifdef VPROC_CFG_VSTART_EN
                vstart_d   = '0;
`endif
              end
            end
            CFG_VTYPE_READ: res_data_d = cfg_vtype_pack(vill_q, agn_q, vsew_q, lmul_q);
            CFG_VL_READ:    res_data_d = 32'(vl_q);
            CFG_VLENB_READ: res_data_d = 32'(VREG_W / 8);
            CFG_VSTART_WRITE, CFG_VSTART_SET, CFG_VSTART_CLEAR: begin
`ifdef VPROC_CFG_VSTART_EN
              vstart_d = csr_new;
`endif
              res_data_d = 32'(csr_old);
            end
            CFG_VXSAT_WRITE, CFG_VXSAT_SET, CFG_VXSAT_CLEAR: begin
              vxsat_d    = csr_new[0];
              res_data_d = 32'(csr_old);
            end
            CFG_VXRM_WRITE, CFG_VXRM_SET, CFG_VXRM_CLEAR: begin
              vxrm_d     = cfg_vxrm'(csr_new[1:0]);
              res_data_d = 32'(csr_old);
            end
            CFG_VCSR_WRITE, CFG_VCSR_SET, CFG_VCSR_CLEAR: begin
              vxrm_d     = cfg_vxrm'(csr_new[2:1]);
              vxsat_d    = csr_new[0];
              res_data_d = 32'(csr_old);
            end
            default: res_data_d = '0;
          endcase
        end
      end
      RESULT: begin
        if (bus.res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturation from the datapath is sticky and beats a same-cycle CSR clear.
    vxsat_d = vxsat_d | vxsat_set_i;
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      mode_q     <= '0;
      rs1_q      <= '0;
      res_data_q <= '0;
      vsew_q     <= VSEW_8;
      lmul_q     <= LMUL_1;
      agn_q      <= '0;
      vill_q     <= 1'b1;
      vl_q       <= '0;
      vxrm_q     <= VXRM_RNU;
      vxsat_q    <= 1'b0;
`ifdef VPROC_CFG_VSTART_EN
      vstart_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      mode_q     <= mode_d;
      rs1_q      <= rs1_d;
      res_data_q <= res_data_d;
      vsew_q     <= vsew_d;
      lmul_q     <= lmul_d;
      agn_q      <= agn_d;
      vill_q     <= vill_d;
      vl_q       <= vl_d;
      vxrm_q     <= vxrm_d;
      vxsat_q    <= vxsat_d;
`ifdef VPROC_CFG_VSTART_EN
      vstart_q   <= vstart_d;
`endif
    end
  end

  assign bus.op_ready_o  = (state_q == IDLE);
  assign bus.res_valid_o = (state_q == RESULT);
  assign bus.res_id_o    = id_q;
  assign bus.res_data_o  = res_data_q;

  assign vsew_o   = vsew_q;
  assign lmul_o   = lmul_q;
  assign vill_o   = vill_q;
  assign vl_o     = vl_q;
  assign vl_0_o   = (vl_q == '0);
  assign vxrm_o   = vxrm_q;
  assign vstart_o = CFG_VL_W'(vstart_val);

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Directed bench for vproc_cfg_unit (VREG_W=128): vsetvl, CSR ops, commit/kill,
// drain stall, result back-pressure and mid-operation reset.
module tb_vproc_cfg_unit;
  import vproc_cfg_unit_pkg::*;

  localparam int unsigned VREG_W   = 128;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned CFG_VL_W = $clog2(VREG_W) + 1;
`ifdef VPROC_CFG_VSTART_EN
  localparam logic [31:0] VSTART_EXP = 32'd5;
`else
  localparam logic [31:0] VSTART_EXP = 32'd0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                pipe_idle;
  logic                vxsat_set;
  cfg_vsew             vsew;
  cfg_lmul             lmul;
  logic                vill;
  logic [CFG_VL_W-1:0] vl;
  logic                vl_0;
  cfg_vxrm             vxrm;
  logic [CFG_VL_W-1:0] vstart;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [2:0]  next_id     = 3'd1;
  logic [31:0] d;
  int          lat;
  logic [2:0]  rid;

  vproc_cfg_unit_if #(.ID_W(ID_W)) bus ();

  vproc_cfg_unit #(
    .VREG_W   (VREG_W),
    .ID_W     (ID_W),
    .CFG_VL_W (CFG_VL_W)
  ) dut (
    .clk_i        (clk),
    .async_rst_ni (rst_n),
    .bus          (bus),
    .pipe_idle_i  (pipe_idle),
    .vxsat_set_i  (vxsat_set),
    .vsew_o       (vsew),
    .lmul_o       (lmul),
    .vill_o       (vill),
    .vl_o         (vl),
    .vl_0_o       (vl_0),
    .vxrm_o       (vxrm),
    .vstart_o     (vstart)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Non-speculative op from IDLE; returns rd value, cycles from accept to res_valid, result ID.
  task automatic run_op(input string tag, input cfg_op op_a, input cfg_vsew sew_a,
                        input cfg_lmul lmul_a, input logic [1:0] agn_a, input logic vlm_a,
                        input logic kv_a, input logic [31:0] rs1_a, input logic sat_a,
                        output logic [31:0] data, output int cycles, output logic [2:0] id_out);
    bus.op_mode_i  = '{op: op_a, vsew: sew_a, lmul: lmul_a, agnostic: agn_a,
                       vlmax: vlm_a, keep_vl: kv_a};
    bus.op_id_i    = next_id;
    bus.op_rs1_i   = rs1_a;
    bus.op_spec_i  = 1'b0;
    bus.op_valid_i = 1'b1;
    tick();
    bus.op_valid_i = 1'b0;
    vxsat_set      = sat_a;
    cycles = 0;
    while (cycles < 20) begin
      tick();
      vxsat_set = 1'b0;
      cycles++;
      if (bus.res_valid_o) break;
    end
    check({tag, " res_valid"}, 32'(bus.res_valid_o), 32'd1);
    data   = bus.res_data_o;
    id_out = bus.res_id_o;
    tick();
  endtask

  task automatic vset(input string tag, input cfg_vsew sew_a, input cfg_lmul lmul_a,
                      input logic [1:0] agn_a, input logic vlm_a, input logic kv_a,
                      input logic [31:0] rs1_a, input logic [31:0] exp);
    logic [31:0] r;
    int          c;
    logic [2:0]  i;
    logic [2:0]  id_used;
    id_used = next_id;
    run_op(tag, CFG_VSETVL, sew_a, lmul_a, agn_a, vlm_a, kv_a, rs1_a, 1'b0, r, c, i);
    next_id++;
    check({tag, " result"}, r, exp);
    check({tag, " latency"}, 32'(c), 32'd1);
    check({tag, " res_id"}, 32'(i), 32'(id_used));
  endtask

  task automatic csr(input string tag, input cfg_op op_a, input logic [31:0] rs1_a,
                     input logic sat_a, input logic [31:0] exp);
    logic [31:0] r;
    int          c;
    logic [2:0]  i;
    run_op(tag, op_a, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, rs1_a, sat_a, r, c, i);
    next_id++;
    check({tag, " result"}, r, exp);
    check({tag, " latency"}, 32'(c), 32'd1);
  endtask

  initial begin
    pipe_idle          = 1'b1;
    vxsat_set          = 1'b0;
    bus.op_valid_i     = 1'b0;
    bus.op_id_i        = '0;
    bus.op_spec_i      = 1'b0;
    bus.op_mode_i      = '0;
    bus.op_rs1_i       = '0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.res_ready_i    = 1'b1;

    #2 rst_n = 1'b0;
    repeat (2) tick();
    check("rst op_ready", 32'(bus.op_ready_o), 32'd1);
    check("rst res_valid", 32'(bus.res_valid_o), 32'd0);
    check("rst res_data", bus.res_data_o, 32'd0);
    check("rst res_id", 32'(bus.res_id_o), 32'd0);
    check("rst vill", 32'(vill), 32'd1);
    check("rst vsew", 32'(vsew), 32'(VSEW_8));
    check("rst lmul", 32'(lmul), 32'(LMUL_1));
    check("rst vl", 32'(vl), 32'd0);
    check("rst vl_0", 32'(vl_0), 32'd1);
    check("rst vxrm", 32'(vxrm), 32'(VXRM_RNU));
    check("rst vstart", 32'(vstart), 32'd0);
    rst_n = 1'b1;
    tick();

    // vsetvl: integer, fractional, vlmax, keep_vl and clipping cases
    vset("e32m1 avl10", VSEW_32, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd10, 32'd4);
    check("e32m1 vl", 32'(vl), 32'd4);
    check("e32m1 vill", 32'(vill), 32'd0);
    check("e32m1 vl_0", 32'(vl_0), 32'd0);
    check("e32m1 vsew", 32'(vsew), 32'(VSEW_32));
    vset("e8m8 vlmax", VSEW_8, LMUL_8, 2'b00, 1'b1, 1'b0, 32'd0, 32'd128);
    check("e8m8 vl", 32'(vl), 32'd128);
    csr("vtype e8m8", CFG_VTYPE_READ, 32'd0, 1'b0, 32'h0000_0003);
    vset("e16m2 agn", VSEW_16, LMUL_2, 2'b11, 1'b0, 1'b0, 32'd5, 32'd5);
    csr("vtype e16m2", CFG_VTYPE_READ, 32'd0, 1'b0, 32'h0000_00C9);
    vset("e8m1 keep", VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b1, 32'd0, 32'd5);
    check("keep vsew", 32'(vsew), 32'(VSEW_8));
    vset("e8mf2 clip", VSEW_8, LMUL_F2, 2'b00, 1'b0, 1'b0, 32'd100, 32'd8);
    check("clip lmul", 32'(lmul), 32'(LMUL_F2));

    // illegal vtype leaves vsew/lmul alone and zeroes vl
    vset("e32mf2 vill", VSEW_32, LMUL_F2, 2'b00, 1'b0, 1'b0, 32'd10, 32'd0);
    check("vill flag", 32'(vill), 32'd1);
    check("vill vl", 32'(vl), 32'd0);
    check("vill vl_0", 32'(vl_0), 32'd1);
    check("vill vsew kept", 32'(vsew), 32'(VSEW_8));
    check("vill lmul kept", 32'(lmul), 32'(LMUL_F2));
    csr("vtype vill", CFG_VTYPE_READ, 32'd0, 1'b0, 32'h8000_0000);
    csr("vl read", CFG_VL_READ, 32'd0, 1'b0, 32'd0);
    csr("vlenb read", CFG_VLENB_READ, 32'd0, 1'b0, 32'd16);
    vset("e8m1 avl7", VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd7, 32'd7);

    // rounding mode and sticky saturation
    csr("vxrm write", CFG_VXRM_WRITE, 32'd2, 1'b0, 32'd0);
    check("vxrm out", 32'(vxrm), 32'(VXRM_RDN));
    csr("vcsr rd1", CFG_VCSR_SET, 32'd0, 1'b0, 32'h4);
    vxsat_set = 1'b1;
    tick();
    vxsat_set = 1'b0;
    csr("vcsr rd2", CFG_VCSR_SET, 32'd0, 1'b0, 32'h5);
    csr("vxsat clr+set", CFG_VXSAT_CLEAR, 32'd1, 1'b1, 32'd1);
    csr("vcsr rd3", CFG_VCSR_SET, 32'd0, 1'b0, 32'h5);
    csr("vxsat clr", CFG_VXSAT_CLEAR, 32'd1, 1'b0, 32'd1);
    csr("vcsr rd4", CFG_VCSR_SET, 32'd0, 1'b0, 32'h4);

    // speculative op: foreign commit ignored, matching kill drops it
    bus.op_mode_i  = '{op: CFG_VSETVL, vsew: VSEW_8, lmul: LMUL_1, agnostic: 2'b00,
                       vlmax: 1'b0, keep_vl: 1'b0};
    bus.op_id_i    = 3'd5;
    bus.op_rs1_i   = 32'd3;
    bus.op_spec_i  = 1'b1;
    bus.op_valid_i = 1'b1;
    tick();
    bus.op_valid_i = 1'b0;
    check("spec ready", 32'(bus.op_ready_o), 32'd0);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = 3'd2;
    bus.commit_kill_i  = 1'b0;
    tick();
    bus.commit_valid_i = 1'b0;
    repeat (2) tick();
    check("foreign commit res_valid", 32'(bus.res_valid_o), 32'd0);
    check("foreign commit ready", 32'(bus.op_ready_o), 32'd0);
    check("foreign commit vl", 32'(vl), 32'd7);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = 3'd5;
    bus.commit_kill_i  = 1'b1;
    tick();
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
    check("kill ready", 32'(bus.op_ready_o), 32'd1);
    check("kill res_valid", 32'(bus.res_valid_o), 32'd0);
    check("kill vl", 32'(vl), 32'd7);

    // speculative op committed: result two edges after the commit cycle starts
    bus.op_id_i    = 3'd6;
    bus.op_valid_i = 1'b1;
    tick();
    bus.op_valid_i     = 1'b0;
    bus.op_spec_i      = 1'b0;
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = 3'd6;
    tick();
    bus.commit_valid_i = 1'b0;
    check("commit drain res_valid", 32'(bus.res_valid_o), 32'd0);
    tick();
    check("commit res_valid", 32'(bus.res_valid_o), 32'd1);
    check("commit result", bus.res_data_o, 32'd3);
    check("commit res_id", 32'(bus.res_id_o), 32'd6);
    tick();
    check("commit vl", 32'(vl), 32'd3);

    // drain stall, then result back-pressure
    pipe_idle      = 1'b0;
    bus.op_mode_i  = '{op: CFG_VXRM_WRITE, vsew: VSEW_8, lmul: LMUL_1, agnostic: 2'b00,
                       vlmax: 1'b0, keep_vl: 1'b0};
    bus.op_id_i    = 3'd3;
    bus.op_rs1_i   = 32'd1;
    bus.op_valid_i = 1'b1;
    tick();
    bus.op_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall res_valid", 32'(bus.res_valid_o), 32'd0);
      check("stall vxrm", 32'(vxrm), 32'(VXRM_RDN));
      tick();
    end
    pipe_idle       = 1'b1;
    bus.res_ready_i = 1'b0;
    tick();
    check("drained res_valid", 32'(bus.res_valid_o), 32'd1);
    check("drained result", bus.res_data_o, 32'd2);
    check("drained vxrm", 32'(vxrm), 32'(VXRM_RNE));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold res_valid", 32'(bus.res_valid_o), 32'd1);
      check("hold res_data", bus.res_data_o, 32'd2);
      check("hold op_ready", 32'(bus.op_ready_o), 32'd0);
    end
    bus.res_ready_i = 1'b1;
    tick();
    check("released ready", 32'(bus.op_ready_o), 32'd1);
    check("released res_valid", 32'(bus.res_valid_o), 32'd0);

    // reads bypass the drain wait
    pipe_idle = 1'b0;
    csr("vl read busy", CFG_VL_READ, 32'd0, 1'b0, 32'd3);
    pipe_idle = 1'b1;

    // vstart: writable only when the register is built in
    csr("vstart write", CFG_VSTART_WRITE, 32'd5, 1'b0, 32'd0);
    check("vstart out", 32'(vstart), VSTART_EXP);
    csr("vstart read", CFG_VSTART_SET, 32'd0, 1'b0, VSTART_EXP);
    vset("e8m1 avl2", VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0, 32'd2, 32'd2);
    check("vsetvl clears vstart", 32'(vstart), 32'd0);

    // reset while an op is draining
    bus.op_mode_i  = '{op: CFG_VSETVL, vsew: VSEW_8, lmul: LMUL_8, agnostic: 2'b00,
                       vlmax: 1'b1, keep_vl: 1'b0};
    bus.op_id_i    = 3'd4;
    bus.op_valid_i = 1'b1;
    tick();
    bus.op_valid_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort op_ready", 32'(bus.op_ready_o), 32'd1);
    check("abort res_valid", 32'(bus.res_valid_o), 32'd0);
    check("abort vl", 32'(vl), 32'd0);
    check("abort vill", 32'(vill), 32'd1);
    check("abort vxrm", 32'(vxrm), 32'(VXRM_RNU));
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset res_valid", 32'(bus.res_valid_o), 32'd0);
    check("post-reset vl", 32'(vl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
